reduction_feeder: RTL and testbench
===================================

Name: reduction_feeder

Overview:
- Sits directly upstream of reduction_layer and owns its input RAM write port.
- Accepts a valid/ready stream of matmul result words and writes them into consecutive RAM addresses from a configurable base.
- On the last beat it launches reduction_layer with start, start_addr, end_addr and reduction_type, then waits for done.
- Captures reduced_out into a holding register and presents it downstream on a valid/ready interface.

Parameters:
DWIDTH, 20, data word width (RAM word and reduced_out)
AWIDTH, 11, RAM address width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_data  input  DWIDTH  input word
in_last  input  1  final beat of batch
in_ready  output  1  feeder accepts beat
cfg_base_addr  input  AWIDTH  first RAM address of batch; latched on first beat
cfg_reduction_type  input  2  reduction op; latched on first beat
ram_we  output  1  RAM write enable
ram_addr  output  AWIDTH  RAM write address
ram_wdata  output  DWIDTH  RAM write data
red_start  output  1  start to reduction_layer
red_start_addr  output  AWIDTH  batch first address
red_end_addr  output  AWIDTH  batch last written address
red_reduction_type  output  2  latched reduction op
red_done  input  1  reduction_layer done
red_reduced_out  input  DWIDTH  reduction result
out_valid  output  1  result valid
out_data  output  DWIDTH  held result
out_ready  input  1  downstream accepts result
overflow  output  1  sticky: batch truncated at top of address space

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - in_ready rises on the first clock edge after resetn deasserts.
  - Reset mid-operation aborts the batch and any pending result.
- All outputs are registered. A beat is accepted on a rising edge with in_valid and in_ready both high.
- States IDLE, FILL, LAUNCH, WAIT, OUT:
  - IDLE (in_ready=1): on accept, latch cfg_base_addr and cfg_reduction_type, and write in_data at the base address. Write pointer becomes base+1. Go to LAUNCH if in_last, else FILL.
  - FILL (in_ready=1): on accept, write at the pointer, increment the pointer, and go to LAUNCH on in_last. Idle cycles with in_valid=0 hold state.
  - LAUNCH (in_ready=0): red_start=1, red_start_addr=base, red_end_addr=last written address. Go to WAIT next cycle.
  - WAIT: red_start is held at 1 until red_done is sampled high. On that edge: red_start drops to 0, red_reduced_out is captured into out_data, out_valid=1, and the FSM goes to OUT.
  - OUT: out_valid is held until out_ready. On the accepting edge out_valid=0, in_ready=1, and the FSM returns to IDLE.
- Latency:
  - ram_we/addr/wdata are asserted the cycle after acceptance.
  - red_start rises the cycle after the last RAM write, so data is committed before start.
  - out_valid rises the cycle after red_done is sampled.
- in_ready must be 0 the cycle after the last beat is accepted; this is a registered next-state decode.
- Single-beat batch: start_addr equals end_addr.
- Overflow: if a non-last beat is written at address 2^AWIDTH-1, it is treated as last. overflow is set, and it is cleared only by reset. Addresses never wrap.
- red_done outside WAIT is ignored. red_done arriving in the LAUNCH cycle is not sampled; sampling begins in WAIT.
- red_reduction_type and start/end addresses stay stable from LAUNCH until the FSM leaves WAIT.
- No arithmetic on data. Pointer arithmetic is AWIDTH-bit unsigned.

Decomposition:
- Shared package reduction_pkg holds:
  - DWIDTH/AWIDTH defaults;
  - the 2-bit reduction_type encoding constants;
  - the feeder FSM state encoding (3-bit localparams).
- One natural sub-module, reduction_result_holder: captures red_reduced_out on a load pulse and runs the out_valid/out_ready handshake.
- The address counter and FSM stay inline.

Test Plan:
- Six-beat batch:
  - Stimulus: base 0, type 2, data 0x00001..0x00006, last on 6th beat, back-to-back.
  - Required: ram writes to addr 0..5 with matching data; red_start high with start_addr 0, end_addr 5, type 2.
  - Then drive red_done with reduced_out 0x00006 → out_data 0x00006 and out_valid the next cycle.
- Gapped single-beat batch:
  - Stimulus: base 0x10, one beat 0xABCDE with in_last, with in_valid gaps before it.
  - Required: one write at 0x10; start_addr = end_addr = 0x10.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after the result.
  - Required: out_valid and out_data stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1 and a new batch is accepted.
- Overflow:
  - Stimulus: base 0x7FE, four non-last beats.
  - Required: writes at 0x7FE and 0x7FF only; end_addr 0x7FF; overflow=1; the 3rd beat is not accepted until the result is consumed.
- Reset mid-operation:
  - Stimulus: assert resetn=0 during WAIT with red_start=1.
  - Required: red_start, out_valid and ram_we drop to 0 immediately (async); in_ready returns on the first edge after release.
  - A stray red_done afterwards produces no out_valid.

Source files
------------

// File: rtl/reduction_pkg.sv
// ---------------------------------------------------------------------------
// reduction_pkg: shared widths, reduction op codes and feeder FSM encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reduction_pkg;

  localparam int RF_DWIDTH = 20;
  localparam int RF_AWIDTH = 11;

  localparam logic [1:0] RED_SUM  = 2'd0;
  localparam logic [1:0] RED_MAX  = 2'd1;
  localparam logic [1:0] RED_MIN  = 2'd2;
  localparam logic [1:0] RED_MEAN = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FILL   = ST_FILL,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT   = ST_WAIT,
    S_OUT    = ST_OUT
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/reduction_result_holder.sv
// ---------------------------------------------------------------------------
// reduction_result_holder: captures a result on load, offers it via valid/ready.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reduction_result_holder #(
  parameter int DWIDTH = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [DWIDTH-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reduction_feeder.sv
// ---------------------------------------------------------------------------
// reduction_feeder: streams words into RAM, launches reduction_layer, holds result.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reduction_feeder
  import reduction_pkg::*;
#(
  parameter int DWIDTH = RF_DWIDTH,
  parameter int AWIDTH = RF_AWIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] cfg_base_addr,
  input  logic [1:0]        cfg_reduction_type,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              red_start,
  output logic [AWIDTH-1:0] red_start_addr,
  output logic [AWIDTH-1:0] red_end_addr,
  output logic [1:0]        red_reduction_type,
  input  logic              red_done,
  input  logic [DWIDTH-1:0] red_reduced_out,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic              overflow
);

  localparam logic [AWIDTH-1:0] ADDR_TOP = '1;

  feeder_state_t     state;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] beat_addr;
  logic              accept;
  logic              beat_last;
  logic              hold_load;
  logic              consume;

  assign accept    = in_valid & in_ready;
  assign beat_addr = (state == S_IDLE) ? cfg_base_addr : wr_ptr;
  // A beat landing on the top address closes the batch so addresses never wrap.
  assign beat_last = in_last | (beat_addr == ADDR_TOP);
  assign hold_load = (state == S_WAIT) & red_done;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      wr_ptr             <= '0;
      in_ready           <= 1'b0;
      ram_we             <= 1'b0;
      ram_addr           <= '0;
      ram_wdata          <= '0;
      red_start          <= 1'b0;
      red_start_addr     <= '0;
      red_end_addr       <= '0;
      red_reduction_type <= 2'd0;
      overflow           <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            ram_we    <= 1'b1;
            ram_addr  <= beat_addr;
            ram_wdata <= in_data;
            wr_ptr    <= beat_addr + 1'b1;
            if (state == S_IDLE) begin
              red_start_addr     <= cfg_base_addr;
              red_reduction_type <= cfg_reduction_type;
            end
            if (beat_last) begin
              red_end_addr <= beat_addr;
              overflow     <= overflow | ~in_last;
              in_ready     <= 1'b0;
              state        <= S_LAUNCH;
            end else begin
              in_ready <= 1'b1;
              state    <= S_FILL;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        // Start follows the final RAM write by one cycle so the data is committed.
        S_LAUNCH: begin
          red_start <= 1'b1;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (red_done) begin
            red_start <= 1'b0;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (consume) begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  reduction_result_holder #(
    .DWIDTH(DWIDTH)
  ) u_holder (
    .clk       (clk),
    .resetn    (resetn),
    .load      (hold_load),
    .load_data (red_reduced_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_reduction_feeder.sv
// ---------------------------------------------------------------------------
// tb_reduction_feeder: directed and randomized batches against a batch-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reduction_feeder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [19:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [10:0] cfg_base_addr;
  logic [1:0]  cfg_reduction_type;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [19:0] ram_wdata;
  logic        red_start;
  logic [10:0] red_start_addr;
  logic [10:0] red_end_addr;
  logic [1:0]  red_reduction_type;
  logic        red_done;
  logic [19:0] red_reduced_out;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ready;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  bit          ovf_model = 1'b0;
  logic [30:0] wq[$];

  always #5 clk = ~clk;

  reduction_feeder #(.DWIDTH(20), .AWIDTH(11)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .cfg_base_addr      (cfg_base_addr),
    .cfg_reduction_type (cfg_reduction_type),
    .ram_we             (ram_we),
    .ram_addr           (ram_addr),
    .ram_wdata          (ram_wdata),
    .red_start          (red_start),
    .red_start_addr     (red_start_addr),
    .red_end_addr       (red_end_addr),
    .red_reduction_type (red_reduction_type),
    .red_done           (red_done),
    .red_reduced_out    (red_reduced_out),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_ready          (out_ready),
    .overflow           (overflow)
  );

  always @(negedge clk) begin
    if (resetn === 1'b1 && ram_we === 1'b1) wq.push_back({ram_addr, ram_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One batch from the stream's point of view: beats accepted, writes seen,
  // launch contents, result handshake. Returns early in WAIT when abort is set.
  task automatic run_batch(input logic [10:0] base, input logic [1:0] typ, input int n,
                           input bit use_last, input int min_gap, input int max_gap,
                           input bit rnd_data, input logic [19:0] first_data,
                           input logic [19:0] result, input int bp, input bit abort);
    logic [19:0] d[$];
    int          avail;
    int          acc;
    int          tries;
    logic [10:0] last_addr;
    avail = 2048 - int'(base);
    acc   = (n < avail) ? n : avail;
    if (acc == avail && !(use_last && n == acc)) ovf_model = 1'b1;
    last_addr = 11'(int'(base) + acc - 1);
    for (int i = 0; i < n; i++) d.push_back(rnd_data ? 20'($urandom) : 20'(first_data + 20'(i)));
    wq.delete();

    for (int i = 0; i < acc; i++) begin
      repeat ($urandom_range(min_gap, max_gap)) begin
        in_valid        = 1'b0;
        red_done        = 1'($urandom_range(0, 1));
        red_reduced_out = 20'($urandom);
        @(negedge clk);
        chk("out_valid_idle", out_valid, 0);
      end
      in_valid           = 1'b1;
      in_data            = d[i];
      in_last            = use_last && (i == n - 1);
      red_done           = 1'b0;
      cfg_base_addr      = (i == 0) ? base : 11'($urandom);
      cfg_reduction_type = (i == 0) ? typ : 2'($urandom);
      tries = 0;
      while (in_ready !== 1'b1 && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      chk("in_ready_wait", in_ready, 1);
      @(negedge clk);
      if (i != acc - 1) chk("in_ready_fill", in_ready, 1);
    end

    // Launch cycle: last write on the RAM port, start not yet raised.
    if (acc < n) begin
      in_valid = 1'b1;
      in_data  = 20'($urandom);
      in_last  = 1'b0;
    end else begin
      in_valid = 1'b0;
    end
    chk("in_ready_after_last", in_ready, 0);
    chk("ram_we_last", ram_we, 1);
    chk("ram_addr_last", ram_addr, last_addr);
    chk("red_start_early", red_start, 0);
    red_done        = 1'($urandom_range(0, 1));
    red_reduced_out = 20'($urandom);
    @(negedge clk);
    red_done = 1'b0;
    chk("red_start", red_start, 1);
    chk("start_addr", red_start_addr, base);
    chk("end_addr", red_end_addr, last_addr);
    chk("red_type", red_reduction_type, typ);
    chk("overflow", overflow, ovf_model);
    chk("write_count", wq.size(), acc);
    for (int i = 0; i < acc && i < wq.size(); i++)
      chk("ram_write", wq[i], {11'(int'(base) + i), d[i]});
    if (abort) return;

    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("wait_start_held", red_start, 1);
      chk("wait_no_valid", out_valid, 0);
      chk("wait_in_ready", in_ready, 0);
    end
    red_done        = 1'b1;
    red_reduced_out = result;
    @(negedge clk);
    red_done        = 1'b0;
    red_reduced_out = 20'($urandom);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, result);
    chk("start_dropped", red_start, 0);
    chk("out_in_ready", in_ready, 0);
    out_ready = 1'b0;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, result);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("consumed_valid", out_valid, 0);
    chk("consumed_in_ready", in_ready, 1);
    chk("no_extra_writes", wq.size(), acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_base_addr = '0; cfg_reduction_type = '0; red_done = 1'b0;
    red_reduced_out = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_red_start", red_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;
    #1 chk("release_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("release_in_ready_high", in_ready, 1);

    // Six-beat back-to-back batch.
    run_batch(11'h000, 2'd2, 6, 1'b1, 0, 0, 1'b0, 20'h00001, 20'h00006, 0, 1'b0);
    // Gapped single-beat batch with ten cycles of backpressure.
    run_batch(11'h010, 2'd1, 1, 1'b1, 1, 3, 1'b0, 20'hABCDE, 20'h5A5A5, 10, 1'b0);
    // Randomized batches.
    for (int k = 0; k < 6; k++)
      run_batch(11'($urandom_range(0, 2040)), 2'($urandom), int'($urandom_range(1, 8)),
                1'b1, 0, 2, 1'b1, 20'h0, 20'($urandom), int'($urandom_range(0, 3)), 1'b0);
    // Overflow: four non-last beats from 0x7FE, only two fit.
    run_batch(11'h7FE, 2'd3, 4, 1'b0, 0, 0, 1'b1, 20'h0, 20'h12345, 3, 1'b0);
    run_batch(11'h100, 2'd0, 3, 1'b1, 0, 1, 1'b1, 20'h0, 20'h0BEEF, 1, 1'b0);

    // Reset while waiting for done.
    run_batch(11'h200, 2'd1, 3, 1'b1, 0, 0, 1'b1, 20'h0, 20'h0, 0, 1'b1);
    #2 resetn = 1'b0;
    ovf_model = 1'b0;
    #1;
    chk("abort_red_start", red_start, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_overflow", overflow, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("rerelease_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rerelease_in_ready_high", in_ready, 1);
    red_done = 1'b1;
    red_reduced_out = 20'hFFFFF;
    repeat (2) @(negedge clk);
    red_done = 1'b0;
    chk("stray_done_no_valid", out_valid, 0);
    run_batch(11'h3A0, 2'd2, 5, 1'b1, 0, 2, 1'b1, 20'h0, 20'($urandom), 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
